// File: rtl/fifo_serial_tx_pkg.sv
// Shared types and helpers for the FIFO-fed serial transmitter.
package fifo_serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_e;

  // Clock cycles occupied by one frame: start bit, data bits, stop bit.
  function automatic int unsigned frame_len(input int unsigned data_width,
                                            input int unsigned clks_per_bit);
    return (data_width + 2) * clks_per_bit;
  endfunction

endpackage

// File: rtl/fifo_serial_tx_if.sv
// Read port between the transmitter and the upstream FIFO.
interface fifo_serial_tx_if #(
  parameter int DATA_WIDTH = 4
) ();

  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_rd_val;

  // Transmitter side: issues reads, receives data.
  modport master (
    output fifo_rd_en,
    input  fifo_rd_data,
    input  fifo_rd_val
  );

  // FIFO side: receives reads, returns data.
  modport slave (
    input  fifo_rd_en,
    output fifo_rd_data,
    output fifo_rd_val
  );

endinterface

// File: rtl/fifo_serial_tx_bit_timer.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1, pulses done on the last count.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: hold at zero while cleared, wrap after the last count.
  always_comb begin
    cnt_d = cnt_q;
    if (clear || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Done decoded from the registered count.
  always_comb begin
    done = (cnt_q == LAST);
  end

endmodule

// File: rtl/fifo_serial_tx.sv
// Pulls words from a 1-cycle-latency FIFO and sends them as start/data/stop frames.
module fifo_serial_tx
  import fifo_serial_pkg::*;
#(
  parameter int DATA_WIDTH   = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  fifo_serial_tx_if.master        fifo,
  output logic                    tx,
  output logic                    busy
);

  localparam int IW = $clog2(DATA_WIDTH) + 1;
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_WIDTH - 1);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  bit_done;
  logic                  timer_clr;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .reset(reset),
    .clear(timer_clr),
    .done (bit_done)
  );

  // Next-state, shift register and bit index.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    unique case (state_q)
      ST_IDLE:  state_d = ST_REQ;
      ST_REQ:   state_d = ST_WAIT;
      ST_WAIT: begin
        if (fifo.fifo_rd_val) begin
          shift_d = fifo.fifo_rd_data;
          idx_d   = '0;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_done) begin
          idx_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (idx_q == LAST_BIT) begin
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          state_d = ST_IDLE;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

  // Outputs decoded only from registered state and shift register.
  always_comb begin
    fifo.fifo_rd_en = 1'b0;
    tx              = 1'b1;
    busy            = 1'b0;
    timer_clr       = 1'b1;
    unique case (state_q)
      ST_REQ:   fifo.fifo_rd_en = 1'b1;
      ST_START: begin
        tx        = 1'b0;
        busy      = 1'b1;
        timer_clr = 1'b0;
      end
      ST_DATA: begin
        tx        = shift_q[0];
        busy      = 1'b1;
        timer_clr = 1'b0;
      end
      ST_STOP: begin
        busy      = 1'b1;
        timer_clr = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/fifo_serial_tx.md
FIFO_SERIAL_TX -- requirements
Module: fifo_serial_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 4, width of each FIFO word and of the serial data field.
REQ-002 Parameter CLKS_PER_BIT, default 4, clk cycles per serial bit time (>=1).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 fifo_rd_en  output  1  read request to the upstream FIFO (drives its rd_en).
REQ-006 fifo_rd_data  input  DATA_WIDTH  word returned by the FIFO (from its rd_data).
REQ-007 fifo_rd_val  input  1  FIFO read-data valid (from its rd_val).
REQ-008 tx  output  1  serial line, idle high.
REQ-009 busy  output  1  high while a frame is on the line.

Function
REQ-010 FSM states SHALL be IDLE, REQ, WAIT, START, DATA, STOP; all outputs SHALL be decoded from registered state/counters (no input-to-output paths).
REQ-011 IDLE SHALL last exactly one cycle, then go to REQ.
REQ-012 REQ SHALL last one cycle with fifo_rd_en=1, then go to WAIT; fifo_rd_en SHALL be 0 in every other state.
REQ-013 FIFO read latency is one cycle: in WAIT, fifo_rd_val=1 SHALL capture fifo_rd_data into the shift register and go to START; fifo_rd_val=0 (FIFO empty) SHALL go to IDLE with nothing captured.
REQ-014 fifo_rd_val/fifo_rd_data SHALL be ignored in every state except WAIT.
REQ-015 START SHALL drive tx=0 for CLKS_PER_BIT cycles.
REQ-016 DATA SHALL drive DATA_WIDTH bits LSB first, each for CLKS_PER_BIT cycles; bit index counter width clog2(DATA_WIDTH)+1, no wrap beyond DATA_WIDTH-1.
REQ-017 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
REQ-018 Frame length SHALL be exactly (DATA_WIDTH+2)*CLKS_PER_BIT cycles; minimum gap between frames SHALL be 3 cycles (IDLE, REQ, WAIT) of tx=1.
REQ-019 tx SHALL be 1 in IDLE, REQ, WAIT; busy SHALL be 1 exactly in START, DATA, STOP.
REQ-020 Empty FIFO SHALL produce a fifo_rd_en pulse every 3 cycles and no tx activity.
REQ-021 CLKS_PER_BIT=1 SHALL work with no extra cycles per bit.

Reset
REQ-022 reset high at a clk edge SHALL force state IDLE, tx=1, busy=0, fifo_rd_en=0, bit timer and bit index to 0, shift register to 0.
REQ-023 Reset mid-frame SHALL abort the frame at the next edge (tx=1) and drop the word; no re-read of it.
REQ-024 First fifo_rd_en after reset release SHALL occur in the second cycle after the last reset-high edge (IDLE then REQ).

Structure
REQ-025 State enum and frame-length helper constant SHALL live in shared package fifo_serial_pkg.
REQ-026 Per-bit timing SHALL be one sub-module bit_timer (count 0..CLKS_PER_BIT-1, one-cycle done pulse, clear input).
REQ-027 Top connects directly to the existing FIFO: FIFO_DEPTH=4, DATA_WIDTH=4 in the bench.

Verification
REQ-028 Single word: write 6, default params -> tx = 0 x4, then 0,1,1,0 each x4, then 1 x4; busy high 24 cycles.
REQ-029 Empty FIFO after reset -> fifo_rd_en pulses at cycles 2, 5, 8...; tx constant 1, busy 0.
REQ-030 Back-to-back: write 6, 8, 4, 10 -> four frames in order, 3-cycle tx-high gap between stop and next start; fifth read sees fifo_rd_val=0.
REQ-031 Reset asserted 10 cycles into frame of 12 -> tx=1, busy=0 next edge; after release next frame carries next FIFO word, not 12.
REQ-032 CLKS_PER_BIT=1, DATA_WIDTH=4, word 9 -> tx 0,1,0,0,1,1 on consecutive cycles.
REQ-033 Bench SHALL check fifo_rd_en never high outside REQ and fifo_rd_data ignored when fifo_rd_val=0.
